// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MAR/MDR memory-access controller.
package mem_ctrl_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int RAM_READ_LATENCY = 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPTURE,
        WR_ISSUE,
        DONE
    } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// MAR/MDR owner sequencing single-word reads and writes to the synchronous RAM.
// Every output is a flop; requests and loads are only honoured in IDLE.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic                  mar_in,
    input  logic                  mdr_in,
    input  logic                  rd_req,
    input  logic                  wr_req,
    output logic [DATA_WIDTH-1:0] mdr_out,
    output logic                  busy,
    output logic                  done,
    output logic                  addr_err,
    output logic                  cmd_err,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_write_enable,
    output logic                  ram_read_enable,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    state_t                state;
    logic [DATA_WIDTH-1:0] mar;
    logic [DATA_WIDTH-1:0] mdr;
    logic [DATA_WIDTH-1:0] eff_mar;
    logic                  out_of_range;

    // A request issued together with a MAR load must see the new address.
    assign eff_mar      = mar_in ? bus_in : mar;
    assign out_of_range = |eff_mar[DATA_WIDTH-1:ADDR_WIDTH];

    assign mdr_out     = mdr;
    assign ram_data_in = mdr;

    // NOTE: non-blocking throughout so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state            <= IDLE;
            mar              <= '0;
            mdr              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            addr_err         <= 1'b0;
            cmd_err          <= 1'b0;
            ram_address      <= '0;
            ram_write_enable <= 1'b0;
            ram_read_enable  <= 1'b0;
        end else begin
            done             <= 1'b0;
            cmd_err          <= 1'b0;
            ram_write_enable <= 1'b0;
            ram_read_enable  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mar_in) mar <= bus_in;
                    if (mdr_in) mdr <= bus_in;
                    if (rd_req && wr_req) begin
                        cmd_err <= 1'b1;
                    end else if (rd_req || wr_req) begin
                        busy <= 1'b1;
                        if (out_of_range) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            addr_err <= 1'b1;
                        end else begin
                            addr_err    <= 1'b0;
                            ram_address <= eff_mar[ADDR_WIDTH-1:0];
                            if (rd_req) begin
                                state           <= RD_ISSUE;
                                ram_read_enable <= 1'b1;
                            end else begin
                                state            <= WR_ISSUE;
                                ram_write_enable <= 1'b1;
                            end
                        end
                    end
                end
                RD_ISSUE: state <= RD_CAPTURE;
                RD_CAPTURE: begin
                    // RAM data registered at the RD_ISSUE closing edge is valid now.
                    mdr   <= ram_data_out;
                    state <= DONE;
                    done  <= 1'b1;
                end
                WR_ISSUE: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: behavioural RAM behind the controller plus a
// transaction-level model of MDR, addr_err and memory contents.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        clear_n;
    logic [31:0] bus_in;
    logic        mar_in, mdr_in, rd_req, wr_req;
    logic [31:0] mdr_out;
    logic        busy, done, addr_err, cmd_err;
    logic [7:0]  ram_address;
    logic [31:0] ram_data_in;
    logic        ram_write_enable, ram_read_enable;
    logic [31:0] ram_data_out = '0;

    logic [31:0] ram_mem [256];
    logic [31:0] gmem    [256];
    logic [31:0] m_mdr;
    logic        m_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk              (clk),
        .clear_n          (clear_n),
        .bus_in           (bus_in),
        .mar_in           (mar_in),
        .mdr_in           (mdr_in),
        .rd_req           (rd_req),
        .wr_req           (wr_req),
        .mdr_out          (mdr_out),
        .busy             (busy),
        .done             (done),
        .addr_err         (addr_err),
        .cmd_err          (cmd_err),
        .ram_address      (ram_address),
        .ram_data_in      (ram_data_in),
        .ram_write_enable (ram_write_enable),
        .ram_read_enable  (ram_read_enable),
        .ram_data_out     (ram_data_out)
    );

    // RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
        if (ram_read_enable)  ram_data_out <= ram_mem[ram_address];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request from IDLE, monitored until well after completion.
    task automatic txn(input bit rd, input logic [31:0] addr, input bit load_mdr,
                       input logic [31:0] data, input bit mar_early, input bit disturb,
                       input string tag);
        bit legal;
        int lat, done_cnt, done_at, rd_cnt, wr_cnt, both, addr_bad, wdata_bad;
        logic [31:0] mdr_at_done;
        legal = (addr[31:8] == 24'd0);
        lat = !legal ? 1 : (rd ? 2 + RAM_READ_LATENCY : 2);
        done_cnt = 0; done_at = -1; rd_cnt = 0; wr_cnt = 0; both = 0;
        addr_bad = 0; wdata_bad = 0; mdr_at_done = 'x;

        if (load_mdr) begin
            bus_in = data; mdr_in = 1'b1; tick(); mdr_in = 1'b0;
            m_mdr = data;
        end
        bus_in = addr; mar_in = 1'b1;
        if (mar_early) begin
            tick(); mar_in = 1'b0; bus_in = $urandom;
        end
        rd_req = rd; wr_req = !rd;
        tick();
        mar_in = 1'b0; rd_req = 1'b0; wr_req = 1'b0; bus_in = $urandom;

        for (int c = 1; c <= 6; c++) begin
            if (c == 1) check({tag, " busy"}, 32'(busy), 32'd1);
            if (legal && c <= lat && ram_address !== addr[7:0]) addr_bad++;
            if (ram_read_enable) rd_cnt++;
            if (ram_write_enable) begin
                wr_cnt++;
                if (ram_data_in !== m_mdr) wdata_bad++;
            end
            if (ram_read_enable && ram_write_enable) both++;
            if (done) begin
                done_cnt++; done_at = c; mdr_at_done = mdr_out;
            end
            if (disturb && c <= lat) begin
                bus_in = 32'hDEADBEEF; mdr_in = 1'b1; rd_req = 1'b1;
            end else begin
                mdr_in = 1'b0; rd_req = 1'b0;
            end
            tick();
        end

        if (legal && !rd) gmem[addr[7:0]] = m_mdr;
        if (legal && rd)  m_mdr = gmem[addr[7:0]];
        m_err = !legal;

        check({tag, " done_cycle"}, 32'(done_at), 32'(lat));
        check({tag, " done_count"}, 32'(done_cnt), 32'd1);
        check({tag, " rd_strobes"}, 32'(rd_cnt), 32'(legal && rd));
        check({tag, " wr_strobes"}, 32'(wr_cnt), 32'(legal && !rd));
        check({tag, " strobe_overlap"}, 32'(both), 32'd0);
        check({tag, " addr_stable"}, 32'(addr_bad), 32'd0);
        check({tag, " wdata"}, 32'(wdata_bad), 32'd0);
        if (legal && rd) check({tag, " mdr_at_done"}, mdr_at_done, m_mdr);
        check({tag, " mdr_out"}, mdr_out, m_mdr);
        check({tag, " addr_err"}, 32'(addr_err), 32'(m_err));
        check({tag, " busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dcnt;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = $urandom;
            gmem[i]    = ram_mem[i];
        end
        ram_mem[8'h68] = 32'h55; gmem[8'h68] = 32'h55;
        ram_mem[8'h54] = 32'h97; gmem[8'h54] = 32'h97;

        clear_n = 1'b0; bus_in = '0; mar_in = 0; mdr_in = 0; rd_req = 0; wr_req = 0;
        m_mdr = '0; m_err = 1'b0;
        tick(); tick();
        check("rst mdr_out", mdr_out, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst addr_err", 32'(addr_err), 32'd0);
        check("rst cmd_err", 32'(cmd_err), 32'd0);
        check("rst ram_address", 32'(ram_address), 32'd0);
        check("rst ram_data_in", ram_data_in, 32'd0);
        check("rst strobes", 32'({ram_read_enable, ram_write_enable}), 32'd0);
        clear_n = 1'b1;
        tick();

        txn(1, 32'h68, 0, 0, 1, 0, "read68");
        txn(0, 32'h52, 1, 32'h2F, 0, 0, "write52");
        txn(1, 32'h52, 0, 0, 0, 0, "read52");
        txn(1, 32'h154, 0, 0, 0, 0, "range_err");
        txn(1, 32'h54, 0, 0, 0, 0, "read54");

        // Conflicting command: pulse only, no transaction.
        rd_req = 1'b1; wr_req = 1'b1;
        tick();
        rd_req = 1'b0; wr_req = 1'b0;
        check("cmd cmd_err", 32'(cmd_err), 32'd1);
        check("cmd busy", 32'(busy), 32'd0);
        check("cmd strobes", 32'({ram_read_enable, ram_write_enable}), 32'd0);
        check("cmd done", 32'(done), 32'd0);
        dcnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done || busy || cmd_err || ram_read_enable || ram_write_enable) dcnt++;
        end
        check("cmd quiet_after", 32'(dcnt), 32'd0);

        // Reset while in RD_CAPTURE.
        bus_in = 32'h10; mar_in = 1'b1; rd_req = 1'b1;
        tick();
        mar_in = 1'b0; rd_req = 1'b0;
        tick();
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
        m_mdr = '0; m_err = 1'b0;
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid done", 32'(done), 32'd0);
        check("rst_mid mdr_out", mdr_out, 32'd0);
        check("rst_mid strobes", 32'({ram_read_enable, ram_write_enable}), 32'd0);
        check("rst_mid ram_address", 32'(ram_address), 32'd0);
        dcnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done || busy) dcnt++;
        end
        check("rst_mid no_done", 32'(dcnt), 32'd0);

        txn(1, 32'h68, 0, 0, 0, 1, "busy_gate");

        for (int n = 0; n < 40; n++) begin
            bit rd;
            logic [31:0] a;
            rd = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h100;
            else a = 32'($urandom_range(0, 255));
            txn(rd, a, rd ? 1'($urandom_range(0, 1)) : 1'b1, $urandom,
                1'($urandom_range(0, 1)), rd && ($urandom_range(0, 1) == 1), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
